aes_cipher: RTL and testbench

//  - Fully pipelined AES-256 encryption core (FIPS-197, ECB) for block-cipher datapaths (e.g. GCM/CTR front ends).
//  - Expands a 256-bit key once into 15 round keys.
//  - Then accepts one 128-bit block per cycle.
//  - Returns each ciphertext after a fixed 15-stage pipeline latency.

---
 rtl/aes_pkg.sv | 91 +++++++++
 rtl/aes_round.sv | 23 ++
 rtl/aes_cipher.sv | 189 ++++++++++++++++++
 tb/tb_aes_cipher.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES-256 shared definitions: round/key constants, Rcon table, key FSM state
// type and the byte-level transforms used by the round logic and key schedule.
// State layout: bit 127 is the MSB of byte 0; byte n sits at [127-8n -: 8],
// column c holds bytes 4c..4c+3 (FIPS-197 column-major order).
package aes_pkg;

  localparam int NR            = 14;  // rounds
  localparam int NK            = 8;   // key words
  localparam int EXPAND_CYCLES = 13;  // 52 generated words, 4 per cycle

  // Rcon[i/8] for AES-256; index 0 is never used.
  localparam logic [0:7][7:0] RCON = {8'h00, 8'h01, 8'h02, 8'h04,
                                      8'h08, 8'h10, 8'h20, 8'h40};

  typedef enum logic [1:0] {
    KEY_IDLE,
    KEY_EXPAND,
    KEY_READY
  } key_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0), then the FIPS-197 affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = gf_mul(a, a);
    inv = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int n = 0; n < 16; n++) r[127-8*n -: 8] = sbox(s[127-8*n -: 8]);
    return r;
  endfunction

  // Row r of the state rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    return r;
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped when
// FINAL=1), AddRoundKey.
module aes_round
  import aes_pkg::*;
#(
  parameter bit FINAL = 1'b0
) (
  input  logic [127:0] state_i,
  input  logic [127:0] round_key_i,
  output logic [127:0] state_o
);

  logic [127:0] shifted;

  assign shifted = shift_rows(sub_bytes(state_i));

  if (FINAL) begin : g_final
    assign state_o = shifted ^ round_key_i;
  end else begin : g_full
    assign state_o = mix_columns(shifted) ^ round_key_i;
  end

endmodule

// File: rtl/aes_cipher.sv
// Fully pipelined AES-256 ECB encryption core. A key FSM expands cipher_key
// once into 15 round keys (4 words per cycle); afterwards one block per cycle
// enters a 15-stage pipeline and leaves 14 edges later.
// Optional build macro: AES_CIPHER_CHECK_EN enables simulation-only protocol
// checks ($error); the synthesized logic is identical either way.
module aes_cipher
  import aes_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic [0:127] plain_text,
  input  logic [0:255] cipher_key,
  input  logic         key_valid,
  input  logic         start_conversion,
  input  logic         last_conversion,
  output logic [0:127] cipher_text,
  output logic         ready_text,
  output logic         pipe_ready,
  output logic         done_conversion
);

  // ---------------- key schedule ----------------
  key_state_e   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [31:0]  win_q [0:7];   // sliding window w[i-8..i-1]
  logic [31:0]  win_d [0:7];
  logic [31:0]  new_w [0:3];
  logic         load_key;
  logic         rk_we;
  logic [127:0] rk_q [0:NR];
  logic [255:0] key_w;

  assign key_w = cipher_key;

  // Next four schedule words from the window; i mod 8 alternates 0 / 4 per cycle.
  always_comb begin
    logic [31:0] prev;
    logic [31:0] temp;
    prev = win_q[7];
    for (int j = 0; j < 4; j++) begin
      if (j == 0) begin
        temp = cnt_q[0] ? sub_word(prev)
                        : (sub_word(rot_word(prev)) ^ {RCON[cnt_q[3:1] + 3'd1], 24'h0});
      end else begin
        temp = prev;
      end
      new_w[j] = win_q[j] ^ temp;
      prev     = new_w[j];
    end
  end

  // Key FSM next state and store controls.
  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    load_key = 1'b0;
    rk_we    = 1'b0;
    unique case (state_q)
      KEY_IDLE: begin
        if (key_valid) begin
          state_d  = KEY_EXPAND;
          cnt_d    = '0;
          load_key = 1'b1;
          for (int n = 0; n < 8; n++) win_d[n] = key_w[255-32*n -: 32];
        end
      end
      KEY_EXPAND: begin
        if (!key_valid) begin
          state_d = KEY_IDLE;
        end else begin
          rk_we = 1'b1;
          cnt_d = cnt_q + 4'd1;
          for (int j = 0; j < 4; j++) begin
            win_d[j]   = win_q[j+4];
            win_d[j+4] = new_w[j];
          end
          if (cnt_q == 4'(EXPAND_CYCLES - 1)) state_d = KEY_READY;
        end
      end
      KEY_READY: begin
        if (!key_valid) state_d = KEY_IDLE;
      end
      default: state_d = KEY_IDLE;
    endcase
  end

  // Key FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= KEY_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Schedule window; always loaded from the key before it is consumed.
  always_ff @(posedge clock) begin
    win_q <= win_d;
  end

  // Round-key store. A re-expansion rewrites rk[r] one edge after an in-flight
  // block last read it, so blocks accepted under the old key finish correctly.
  // NOTE: this store is deliberately cleared on reset so no stale key survives;
  // the pipeline data registers below are left unreset because valid bits
  // qualify them.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r <= NR; r++) rk_q[r] <= '0;
    end else begin
      if (load_key) begin
        rk_q[0] <= key_w[255:128];
        rk_q[1] <= key_w[127:0];
      end
      if (rk_we) rk_q[cnt_q + 4'd2] <= {new_w[0], new_w[1], new_w[2], new_w[3]};
    end
  end

  // Gated by key_valid so the core stops accepting in the cycle the key drops.
  assign pipe_ready = (state_q == KEY_READY) && key_valid;

  // ---------------- cipher pipeline ----------------
  logic [127:0] pt_w;
  logic         accept;
  logic [127:0] st_q  [0:NR-1];
  logic [127:0] rnd_d [1:NR];
  logic [127:0] out_q;
  logic [NR:0]  vld_q;
  logic [NR:0]  lst_q;

  assign pt_w   = plain_text;
  assign accept = start_conversion && pipe_ready;

  for (genvar r = 1; r <= NR; r++) begin : g_round
    aes_round #(.FINAL(r == NR)) u_round (
      .state_i     (st_q[r-1]),
      .round_key_i (rk_q[r]),
      .state_o     (rnd_d[r])
    );
  end

  // Valid/last tags travel alongside the data, one bit per stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      lst_q <= '0;
    end else begin
      vld_q <= {vld_q[NR-1:0], accept};
      lst_q <= {lst_q[NR-1:0], accept & last_conversion};
    end
  end

  // Stage 0 (initial AddRoundKey) and round stages 1..13.
  always_ff @(posedge clock) begin
    st_q[0] <= pt_w ^ rk_q[0];
    for (int r = 1; r < NR; r++) st_q[r] <= rnd_d[r];
  end

  // Final stage doubles as the output register and holds between results.
  always_ff @(posedge clock) begin
    if (reset) out_q <= '0;
    else if (vld_q[NR-1]) out_q <= rnd_d[NR];
  end

  assign cipher_text     = out_q;
  assign ready_text      = vld_q[NR];
  assign done_conversion = lst_q[NR];

`ifdef AES_CIPHER_CHECK_EN
  // Simulation-only protocol checks.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (start_conversion && !pipe_ready)
        $error("aes_cipher: start_conversion while pipe_ready=0");
      if (accept && $isunknown(plain_text))
        $error("aes_cipher: X on plain_text at accept");
      if (state_q == KEY_EXPAND && cipher_key !== {rk_q[0], rk_q[1]})
        $error("aes_cipher: cipher_key changed during expansion");
    end
  end
`endif

endmodule

// File: tb/tb_aes_cipher.sv
// Scoreboard bench for aes_cipher: stimulus pushes expected ciphertexts (with
// expected last tag and arrival cycle) and a negedge monitor pops and compares.
module tb_aes_cipher;

  logic         clock;
  logic         reset;
  logic [0:127] plain_text;
  logic [0:255] cipher_key;
  logic         key_valid;
  logic         start_conversion;
  logic         last_conversion;
  logic [0:127] cipher_text;
  logic         ready_text;
  logic         pipe_ready;
  logic         done_conversion;

  aes_cipher dut (
    .clock            (clock),
    .reset            (reset),
    .plain_text       (plain_text),
    .cipher_key       (cipher_key),
    .key_valid        (key_valid),
    .start_conversion (start_conversion),
    .last_conversion  (last_conversion),
    .cipher_text      (cipher_text),
    .ready_text       (ready_text),
    .pipe_ready       (pipe_ready),
    .done_conversion  (done_conversion)
  );

  localparam logic [255:0] FIPS_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] SP_KEY =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] SP_PT [4] = '{
    128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
    128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710};
  localparam logic [127:0] SP_CT [4] = '{
    128'hf3eed1bdb5d2a03c064b5a7e3db181f8, 128'h591ccb10d410ed26dc5ba74a31362870,
    128'hb6ed21b99ca6f4f9f153e7b1beafed1d, 128'h23304b7a39f9f3ff067d8d8f9e24ecc7};

  typedef struct {
    logic [127:0] ct;
    logic         last;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every result pulse must match the head of the scoreboard.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (ready_text) begin
      if (sb.size() == 0) begin
        check("unexpected ready_text", 128'(ready_text), 128'd0);
      end else begin
        e = sb.pop_front();
        check("cipher_text", 128'(cipher_text), e.ct);
        check("done_conversion", 128'(done_conversion), 128'(e.last));
        check("result cycle", 128'(cyc), 128'(e.due));
      end
    end else if (done_conversion) begin
      check("done without ready", 128'(done_conversion), 128'd0);
    end
  end

  // Drive one block for one cycle; accepted blocks arrive 14 edges after the sampling edge.
  task automatic send(input logic [127:0] pt, input logic last,
                      input logic [127:0] ct, input bit accepted);
    plain_text       = pt;
    last_conversion  = last;
    start_conversion = 1'b1;
    if (accepted) sb.push_back('{ct: ct, last: last, due: cyc + 15});
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    start_conversion = 1'b0;
    last_conversion  = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  // Bounded wait for pipe_ready; the cycle count itself is the comparison.
  task automatic wait_ready(input string name, input int expect_cycles);
    int n;
    n = 0;
    while (!pipe_ready && n < 40) begin
      @(negedge clock);
      n++;
    end
    check(name, 128'(n), 128'(expect_cycles));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " cipher_text"}, 128'(cipher_text), 128'd0);
    check({tag, " ready_text"}, 128'(ready_text), 128'd0);
    check({tag, " pipe_ready"}, 128'(pipe_ready), 128'd0);
    check({tag, " done_conversion"}, 128'(done_conversion), 128'd0);
  endtask

  initial begin
    reset            = 1'b1;
    key_valid        = 1'b0;
    start_conversion = 1'b0;
    last_conversion  = 1'b0;
    plain_text       = '0;
    cipher_key       = '0;
    repeat (3) @(negedge clock);
    check_outputs_zero("reset");

    // Key-up: pipe_ready exactly 14 edges after key_valid; early starts ignored.
    reset            = 1'b0;
    cipher_key       = FIPS_KEY;
    key_valid        = 1'b1;
    plain_text       = FIPS_PT;
    last_conversion  = 1'b1;
    start_conversion = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      check("pipe_ready ramp", 128'(pipe_ready), 128'(k == 14));
      if (k == 13) begin
        start_conversion = 1'b0;
        last_conversion  = 1'b0;
      end
    end

    // FIPS-197 C.3.
    send(FIPS_PT, 1'b1, FIPS_CT, 1'b1);
    idle(20);

    // Re-key with the SP800-38A key; pipe_ready drops in the same cycle.
    key_valid = 1'b0;
    #1;
    check("pipe_ready drop", 128'(pipe_ready), 128'd0);
    @(negedge clock);
    cipher_key = SP_KEY;
    key_valid  = 1'b1;
    wait_ready("rekey SP cycles", 14);

    // Four blocks 8 cycles apart, last tag on the fourth.
    for (int i = 0; i < 4; i++) begin
      send(SP_PT[i], 1'(i == 3), SP_CT[i], 1'b1);
      if (i < 3) idle(7);
    end
    idle(20);

    // Same four blocks back-to-back.
    for (int i = 0; i < 4; i++) send(SP_PT[i], 1'(i == 3), SP_CT[i], 1'b1);
    idle(20);

    // Reset with five blocks in flight: they must vanish.
    for (int i = 0; i < 5; i++) send(SP_PT[i % 4], 1'b1, '0, 1'b0);
    start_conversion = 1'b0;
    last_conversion  = 1'b0;
    reset            = 1'b1;
    @(negedge clock);
    check_outputs_zero("mid-flight reset");
    reset = 1'b0;
    wait_ready("rekey after reset cycles", 14);
    idle(3);

    // Block in flight across a key drop finishes with the old key; a start in
    // the drop cycle is refused.
    send(SP_PT[1], 1'b0, SP_CT[1], 1'b1);
    key_valid        = 1'b0;
    plain_text       = FIPS_PT;
    last_conversion  = 1'b1;
    start_conversion = 1'b1;
    #1;
    check("pipe_ready drop with start", 128'(pipe_ready), 128'd0);
    @(negedge clock);
    start_conversion = 1'b0;
    last_conversion  = 1'b0;
    cipher_key       = FIPS_KEY;
    key_valid        = 1'b1;
    wait_ready("rekey FIPS cycles", 14);

    // Key change while READY is ignored.
    cipher_key = SP_KEY;
    send(FIPS_PT, 1'b1, FIPS_CT, 1'b1);
    idle(20);

    check("scoreboard drained", 128'(sb.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
